// File: rtl/csi2tx_pixel_seq_if.sv
// Pixel bus between the sensor front end and csi2tx_pixel_seq, with the
// sequencer outputs that feed the p2b converters.
interface csi2tx_pixel_seq_if;
  // Handshake: there is no ready and no backpressure. A sensor pixel is taken on
  // every rising edge where sensor_pixel_vld is 1, and pixel_data/pixel_cnt are
  // meaningful only in cycles where pixel_data_vld is 1. The two exceptions are
  // pixel_cnt on the line-end strobe cycle and pixel_data_d1, which holds.
  logic        sensor_frame_start;
  logic        sensor_frame_end;
  logic        sensor_pixel_vld;
  logic [31:0] sensor_pixel_data;

  logic [31:0] pixel_data;
  logic [31:0] pixel_data_d1;
  logic        pixel_data_vld;
  logic [2:0]  pixel_cnt;
  logic        sensor_pixel_vld_falling_edge;
  logic        odd_even_line;
  logic [15:0] line_pixel_count;
  logic        line_len_err;

  modport master (
    output sensor_frame_start, sensor_frame_end, sensor_pixel_vld, sensor_pixel_data,
    input  pixel_data, pixel_data_d1, pixel_data_vld, pixel_cnt,
           sensor_pixel_vld_falling_edge, odd_even_line, line_pixel_count, line_len_err
  );

  modport slave (
    input  sensor_frame_start, sensor_frame_end, sensor_pixel_vld, sensor_pixel_data,
    output pixel_data, pixel_data_d1, pixel_data_vld, pixel_cnt,
           sensor_pixel_vld_falling_edge, odd_even_line, line_pixel_count, line_len_err
  );
endinterface

// File: rtl/csi2tx_pixel_seq.sv
// Pixel input sequencer for the CSI-2 TX p2b converters: registers pixels and tracks the
// group index, line end, odd/even line. Optional line length check: CSI2TX_PIXEL_SEQ_LINE_LEN_CHK_EN.
module csi2tx_pixel_seq (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           cfg_pixel_cnt_wrap,
  input  logic [15:0]          cfg_line_pixels,
  csi2tx_pixel_seq_if.slave    bus,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    FRAME_IDLE = 2'd0,
    LINE_IDLE  = 2'd1,
    ACTIVE     = 2'd2,
    LINE_END   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_first;
  logic        w_fs_take;
  logic        r_fe_pend;
  logic [2:0]  r_wrap;
  logic [2:0]  w_cnt_inc;
  logic [31:0] r_data;
  logic [31:0] r_data_d1;
  logic        r_vld;
  logic [2:0]  r_cnt;
  logic        r_odd_even;
  logic [15:0] r_line_cnt;
  logic        r_len_err;

  logic w_fs, w_fe, w_vld;
  assign w_fs  = bus.sensor_frame_start;
  assign w_fe  = bus.sensor_frame_end;
  assign w_vld = bus.sensor_pixel_vld;

  // frame_end always has priority; in ACTIVE it first routes through LINE_END so the
  // strobe is not lost, and r_fe_pend completes the exit to FRAME_IDLE.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_fs_take = 1'b0;
    case (r_state)
      FRAME_IDLE: begin
        if (!w_fe && w_fs) begin
          w_next    = LINE_IDLE;
          w_fs_take = 1'b1;
        end
      end
      LINE_IDLE: begin
        if (w_fe) begin
          w_next = FRAME_IDLE;
        end else if (w_fs) begin
          w_next    = LINE_IDLE;
          w_fs_take = 1'b1;
        end else if (w_vld) begin
          w_next   = ACTIVE;
          w_accept = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_fe) begin
          w_next = LINE_END;
        end else if (w_fs) begin
          w_next    = LINE_IDLE;
          w_fs_take = 1'b1;
        end else if (w_vld) begin
          w_accept = 1'b1;
        end else begin
          w_next = LINE_END;
        end
      end
      LINE_END: begin
        if (w_fe || r_fe_pend) begin
          w_next = FRAME_IDLE;
        end else if (w_fs) begin
          w_next    = LINE_IDLE;
          w_fs_take = 1'b1;
        end else if (w_vld) begin
          w_next   = ACTIVE;
          w_accept = 1'b1;
        end else begin
          w_next = LINE_IDLE;
        end
      end
      default: w_next = FRAME_IDLE;
    endcase
  end

  assign w_first   = w_accept && (r_state != ACTIVE);
  assign w_cnt_inc = (r_cnt == r_wrap) ? 3'd0 : r_cnt + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FRAME_IDLE;
      r_fe_pend <= 1'b0;
      r_wrap    <= 3'd0;
    end else begin
      r_state   <= w_next;
      r_fe_pend <= (r_state == ACTIVE) && w_fe;
      if (r_state == FRAME_IDLE && w_fs_take) r_wrap <= cfg_pixel_cnt_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= 32'd0;
      r_data_d1 <= 32'd0;
      r_vld     <= 1'b0;
    end else begin
      r_vld <= w_accept;
      if (w_accept) begin
        r_data    <= bus.sensor_pixel_data;
        r_data_d1 <= r_data;
      end else if (w_fs_take) begin
        r_data_d1 <= 32'd0;
      end
    end
  end

  // Leaving ACTIVE for LINE_END still advances the index, which leaves the
  // residual partial-group size visible during the strobe cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 3'd0;
    end else if (w_accept) begin
      r_cnt <= w_first ? 3'd0 : w_cnt_inc;
    end else if (r_state == ACTIVE && w_next == LINE_END) begin
      r_cnt <= w_cnt_inc;
    end else begin
      r_cnt <= 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_odd_even <= 1'b0;
      r_line_cnt <= 16'd0;
    end else begin
      if (w_fs_take) begin
        r_odd_even <= 1'b0;
      end else if (r_state == LINE_END) begin
        r_odd_even <= ~r_odd_even;
      end

      if (w_fs_take) begin
        r_line_cnt <= 16'd0;
      end else if (w_accept) begin
        if (w_first) begin
          r_line_cnt <= 16'd1;
        end else if (r_line_cnt != 16'hFFFF) begin
          r_line_cnt <= r_line_cnt + 16'd1;
        end
      end
    end
  end

`ifdef CSI2TX_PIXEL_SEQ_LINE_LEN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_err <= 1'b0;
    end else if (w_fs_take) begin
      r_len_err <= 1'b0;
    end else if (r_state == LINE_END && r_line_cnt != cfg_line_pixels) begin
      r_len_err <= 1'b1;
    end
  end
`else
  logic w_unused_cfg_line_pixels;
  assign w_unused_cfg_line_pixels = ^cfg_line_pixels;
  assign r_len_err = 1'b0;
`endif

  assign bus.pixel_data                    = r_data;
  assign bus.pixel_data_d1                 = r_data_d1;
  assign bus.pixel_data_vld                = r_vld;
  assign bus.pixel_cnt                     = r_cnt;
  assign bus.sensor_pixel_vld_falling_edge = (r_state == LINE_END);
  assign bus.odd_even_line                 = r_odd_even;
  assign bus.line_pixel_count              = r_line_cnt;
  assign bus.line_len_err                  = r_len_err;
  assign o_dbg_state                       = r_state;

endmodule

// File: tb/tb_csi2tx_pixel_seq.sv
// Directed bench for csi2tx_pixel_seq; line length checks follow
// CSI2TX_PIXEL_SEQ_LINE_LEN_CHK_EN when it is defined.
module tb_csi2tx_pixel_seq;

`ifdef CSI2TX_PIXEL_SEQ_LINE_LEN_CHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [2:0]  cfg_wrap;
  logic [15:0] cfg_len;
  logic [1:0]  dbg_state;
  int          checks;
  int          errors;

  csi2tx_pixel_seq_if u_if ();

  csi2tx_pixel_seq u_dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cfg_pixel_cnt_wrap (cfg_wrap),
    .cfg_line_pixels    (cfg_len),
    .bus                (u_if),
    .o_dbg_state        (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic fs, input logic fe, input logic vld, input logic [31:0] d);
    u_if.sensor_frame_start = fs;
    u_if.sensor_frame_end   = fe;
    u_if.sensor_pixel_vld   = vld;
    u_if.sensor_pixel_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Pixels first..n-1 of a line with data base+i, wrap 7.
  task automatic send_line(input int first, input int n, input logic [31:0] base);
    for (int i = first; i < n; i++) begin
      step(1'b0, 1'b0, 1'b1, base + i);
      chk("pix_data", u_if.pixel_data, base + i);
      chk("pix_vld", u_if.pixel_data_vld, 1);
      chk("pix_cnt", u_if.pixel_cnt, i % 8);
      chk("line_cnt", u_if.line_pixel_count, i + 1);
      if (i > 0) chk("pix_d1", u_if.pixel_data_d1, base + i - 1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cfg_wrap = 3'd7;
    cfg_len  = 16'd16;
    u_if.sensor_frame_start = 1'b0;
    u_if.sensor_frame_end   = 1'b0;
    u_if.sensor_pixel_vld   = 1'b0;
    u_if.sensor_pixel_data  = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", dbg_state, 0);
    chk("rst_vld", u_if.pixel_data_vld, 0);
    chk("rst_data", u_if.pixel_data, 0);
    chk("rst_strobe", u_if.sensor_pixel_vld_falling_edge, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 16-pixel line, wrap 7
    step(1'b1, 1'b0, 1'b0, 0);
    chk("fs_state", dbg_state, 1);
    chk("fs_oe", u_if.odd_even_line, 0);
    send_line(0, 16, 32'h0);
    chk("l1_first_d1", u_if.pixel_data_d1, 32'hE);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("l1_strobe", u_if.sensor_pixel_vld_falling_edge, 1);
    chk("l1_end_cnt", u_if.pixel_cnt, 0);
    chk("l1_end_vld", u_if.pixel_data_vld, 0);
    chk("l1_end_lpc", u_if.line_pixel_count, 16);
    chk("l1_end_oe", u_if.odd_even_line, 0);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("l1_post_strobe", u_if.sensor_pixel_vld_falling_edge, 0);
    chk("l1_post_oe", u_if.odd_even_line, 1);
    chk("l1_post_cnt", u_if.pixel_cnt, 0);
    chk("l1_post_lpc", u_if.line_pixel_count, 16);
    chk("l1_err", u_if.line_len_err, 0);

    // 11-pixel line: residual 3
    step(1'b0, 1'b0, 1'b1, 32'h100);
    chk("l2_first_d1", u_if.pixel_data_d1, 32'hF);
    chk("l2_first_cnt", u_if.pixel_cnt, 0);
    chk("l2_first_lpc", u_if.line_pixel_count, 1);
    send_line(1, 11, 32'h100);
    chk("l2_last_data", u_if.pixel_data, 32'h10A);
    chk("l2_last_d1", u_if.pixel_data_d1, 32'h109);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("l2_strobe", u_if.sensor_pixel_vld_falling_edge, 1);
    chk("l2_end_cnt", u_if.pixel_cnt, 3);
    chk("l2_end_lpc", u_if.line_pixel_count, 11);
    chk("l2_hold_d1", u_if.pixel_data_d1, 32'h109);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("l2_post_oe", u_if.odd_even_line, 0);
    chk("l2_err", u_if.line_len_err, CHK);

    // back-to-back lines, one idle cycle
    send_line(0, 4, 32'h200);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("b2b_a_strobe", u_if.sensor_pixel_vld_falling_edge, 1);
    chk("b2b_a_cnt", u_if.pixel_cnt, 4);
    step(1'b0, 1'b0, 1'b1, 32'h300);
    chk("b2b_b0_strobe", u_if.sensor_pixel_vld_falling_edge, 0);
    chk("b2b_b0_vld", u_if.pixel_data_vld, 1);
    chk("b2b_b0_cnt", u_if.pixel_cnt, 0);
    chk("b2b_b0_oe", u_if.odd_even_line, 1);
    chk("b2b_b0_state", dbg_state, 2);
    chk("b2b_b0_lpc", u_if.line_pixel_count, 1);
    send_line(1, 4, 32'h300);
    chk("b2b_b_oe", u_if.odd_even_line, 1);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("b2b_b_strobe", u_if.sensor_pixel_vld_falling_edge, 1);
    chk("b2b_b_cnt", u_if.pixel_cnt, 4);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("b2b_post_oe", u_if.odd_even_line, 0);

    // frame_end while ACTIVE
    send_line(0, 3, 32'h400);
    step(1'b0, 1'b1, 1'b0, 0);
    chk("fe_strobe", u_if.sensor_pixel_vld_falling_edge, 1);
    chk("fe_state", dbg_state, 3);
    chk("fe_cnt", u_if.pixel_cnt, 3);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("fe_idle_state", dbg_state, 0);
    chk("fe_idle_strobe", u_if.sensor_pixel_vld_falling_edge, 0);
    chk("fe_idle_oe", u_if.odd_even_line, 1);
    step(1'b0, 1'b0, 1'b1, 32'hAA);
    chk("idle_pix_vld", u_if.pixel_data_vld, 0);
    chk("idle_pix_data", u_if.pixel_data, 32'h402);
    step(1'b1, 1'b0, 1'b0, 0);
    chk("fs2_state", dbg_state, 1);
    chk("fs2_oe", u_if.odd_even_line, 0);
    chk("fs2_lpc", u_if.line_pixel_count, 0);
    chk("fs2_d1", u_if.pixel_data_d1, 0);
    chk("fs2_err", u_if.line_len_err, 0);

    // simultaneous frame_start and frame_end in FRAME_IDLE
    step(1'b0, 1'b1, 1'b0, 0);
    chk("fe_from_li", dbg_state, 0);
    step(1'b1, 1'b1, 1'b0, 0);
    chk("fs_fe_state", dbg_state, 0);

    // asynchronous reset mid-line at pixel 5
    step(1'b1, 1'b0, 1'b0, 0);
    send_line(0, 6, 32'h500);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_state", dbg_state, 0);
    chk("mr_data", u_if.pixel_data, 0);
    chk("mr_d1", u_if.pixel_data_d1, 0);
    chk("mr_vld", u_if.pixel_data_vld, 0);
    chk("mr_cnt", u_if.pixel_cnt, 0);
    chk("mr_strobe", u_if.sensor_pixel_vld_falling_edge, 0);
    chk("mr_lpc", u_if.line_pixel_count, 0);
    chk("mr_err", u_if.line_len_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, 32'h5A);
    chk("mr_nofs_vld", u_if.pixel_data_vld, 0);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("mr_nofs_strobe", u_if.sensor_pixel_vld_falling_edge, 0);

    // line length check: 15 then 16 pixels
    step(1'b1, 1'b0, 1'b0, 0);
    chk("lc_fs_err", u_if.line_len_err, 0);
    send_line(0, 15, 32'h600);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("lc15_strobe", u_if.sensor_pixel_vld_falling_edge, 1);
    chk("lc15_cnt", u_if.pixel_cnt, 7);
    chk("lc15_lpc", u_if.line_pixel_count, 15);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("lc15_err", u_if.line_len_err, CHK);
    send_line(0, 16, 32'h700);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("lc16_cnt", u_if.pixel_cnt, 0);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("lc16_err", u_if.line_len_err, CHK);

    // frame_start mid-line: no strobe, flags cleared
    send_line(0, 2, 32'h800);
    step(1'b1, 1'b0, 1'b1, 32'h8FF);
    chk("rs_state", dbg_state, 1);
    chk("rs_strobe", u_if.sensor_pixel_vld_falling_edge, 0);
    chk("rs_vld", u_if.pixel_data_vld, 0);
    chk("rs_oe", u_if.odd_even_line, 0);
    chk("rs_err", u_if.line_len_err, 0);
    chk("rs_lpc", u_if.line_pixel_count, 0);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("rs_post_strobe", u_if.sensor_pixel_vld_falling_edge, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csi2tx_pixel_seq.md
# csi2tx_pixel_seq

Pixel input sequencer directly upstream of the CSI-2 TX pixel-to-byte converters (legacy YUV420 8-bit and siblings). It registers the sensor pixel bus and generates the per-pixel group index. It also provides a one-cycle-delayed pixel copy, the line-end (valid falling-edge) strobe and the odd/even line flag. Every p2b stage consumes these signals directly on the same clock.

## Interface
- cfg_pixel_cnt_wrap, input [2:0]: last group index before wrap to 0; 3'd7 for legacy YUV420 8-bit. Sampled only in FRAME_IDLE.
- clk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- sensor_frame_start  in  1  single-cycle frame start pulse
- sensor_frame_end  in  1  single-cycle frame end pulse
- sensor_pixel_vld  in  1  high for every valid pixel of a line
- sensor_pixel_data  in  32  raw pixel ([27:20] Y, [17:10] U, [7:0] V)
- cfg_pixel_cnt_wrap  in  3  group wrap value (see above)
- cfg_line_pixels  in  16  expected pixels per line (used only with the macro)
- pixel_data  out  32  registered sensor_pixel_data
- pixel_data_d1  out  32  pixel_data delayed one more valid pixel
- pixel_data_vld  out  1  pixel_data qualifier
- pixel_cnt  out  3  group index of pixel_data; residual count on the line-end cycle
- sensor_pixel_vld_falling_edge  out  1  one-cycle line-end strobe
- odd_even_line  out  1  0 = odd line (U), 1 = even line (V)
- line_pixel_count  out  16  pixels received on the current/last line
- line_len_err  out  1  sticky line length mismatch flag

## Operation
- The state machine has four states: FRAME_IDLE, LINE_IDLE, ACTIVE and LINE_END.
- FRAME_IDLE -> LINE_IDLE on sensor_frame_start.
  - The same transition clears odd_even_line to 0, clears line_pixel_count, and latches cfg_pixel_cnt_wrap.
- LINE_IDLE -> ACTIVE on sensor_pixel_vld.
- ACTIVE -> LINE_END when sensor_pixel_vld falls.
- LINE_END -> LINE_IDLE on the next cycle, or -> ACTIVE if sensor_pixel_vld is already high again.
- Any state -> FRAME_IDLE on sensor_frame_end.
  - If frame_end arrives while ACTIVE, the falling-edge strobe is still generated first, and the transition to FRAME_IDLE follows.
- Pixels while in FRAME_IDLE are ignored: pixel_data_vld stays 0.
- pixel_cnt behaviour:
  - Resets to 0 at the first pixel of each line.
  - Increments after each valid pixel and wraps to 0 after reaching the latched wrap value.
  - On the LINE_END cycle it holds the next index, which is the number of pixels in the trailing partial group; 0 means the group is complete.
  - Cleared to 0 on the cycle after LINE_END.
- pixel_data_d1 loads the old pixel_data only when a new valid pixel is registered. It holds across line gaps, and is cleared at frame start.
- odd_even_line toggles on each LINE_END cycle and takes its new value in the following cycle.
- line_pixel_count:
  - Increments per valid pixel and saturates at 16'hFFFF.
  - Holds its value in LINE_END and LINE_IDLE until the next line's first pixel, which reloads it to 1.

## Timing
- Reset values of all outputs are 0; state is FRAME_IDLE.
- Latency: sensor input to pixel_data/pixel_data_vld/pixel_cnt is 1 cycle.
- sensor_pixel_vld_falling_edge is high exactly one cycle: the first cycle in which pixel_data_vld is 0 after being 1.
- Back-to-back lines (vld low for exactly 1 cycle) must produce both a line-end strobe and a correct restart at pixel_cnt 0.
- Simultaneous frame_start and frame_end: frame_end wins and the state stays FRAME_IDLE.
- frame_start while not in FRAME_IDLE restarts the frame:
  - odd_even_line is cleared.
  - An in-flight line is terminated without a falling-edge strobe.
- Reset mid-line: all outputs return to 0 asynchronously, and the line-end strobe is lost.

## Configuration
- CSI2TX_PIXEL_SEQ_LINE_LEN_CHK_EN defined:
  - On each LINE_END, line_pixel_count is compared with cfg_line_pixels.
  - A mismatch sets line_len_err, which stays set until the next sensor_frame_start or reset.
- Undefined: line_len_err is tied to 0, and the compare logic and cfg_line_pixels usage are removed.

## Test plan
- Wrap 7, one line of 16 pixels (data 0x0..0xF):
  - pixel_cnt cycles 0..7 twice.
  - Strobe fires with pixel_cnt=0.
  - line_pixel_count=16; odd_even_line goes 0 -> 1.
- Line of 11 pixels:
  - Strobe fires with pixel_cnt=3.
  - pixel_data_d1 = pixel 9 while pixel_data = pixel 10.
- Two lines separated by 1 idle cycle:
  - Two strobes are generated.
  - The second line starts at pixel_cnt 0; odd_even_line reads 1 during line 2.
- Reset mid-line and frame checks:
  - rst_n low at pixel 5: all outputs read 0 and the state is FRAME_IDLE.
  - Pixels before a new frame_start produce no pixel_data_vld.
- frame_end while ACTIVE: strobe issued, then FRAME_IDLE; the next frame_start clears odd_even_line to 0.
- With the macro, cfg_line_pixels=16:
  - A 15-pixel line sets line_len_err.
  - It stays set through a following 16-pixel line and clears on frame_start.
